// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : rggen_rtl_pkg
// Description : Shared access direction, response status and external window
//               addressing mode types for the register block slice.
// Revision    : 1.0 - initial release
//==============================================================================
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        BYTE_OFFSET = 1'b0,
        WORD_INDEX  = 1'b1
    } rggen_external_mode;

endpackage
`default_nettype wire

// File: rtl/rggen_bus_if.sv
`default_nettype none
//==============================================================================
// Module      : rggen_bus_if
// Description : Simple request/acknowledge bus toward an external slave.
//               done marks the cycle in which an outstanding request is acked.
// Revision    : 1.0 - initial release
//==============================================================================
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      ack;
    logic [DATA_WIDTH-1:0]     read_data;
    rggen_status               status;
    logic                      done;

    assign done = request & ack;

    modport master (
        output request,
        output address,
        output direction,
        output write_data,
        output write_strobe,
        input  done,
        input  read_data,
        input  status
    );

    modport slave (
        input  request,
        input  address,
        input  direction,
        input  write_data,
        input  write_strobe,
        input  done,
        output ack,
        output read_data,
        output status
    );

endinterface
`default_nettype wire

// File: rtl/rggen_register_if.sv
`default_nettype none
//==============================================================================
// Module      : rggen_register_if
// Description : Local register access interface shared by all register slots.
// Revision    : 1.0 - initial release
//==============================================================================
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      ready;
    rggen_status               status;
    logic [DATA_WIDTH-1:0]     read_data;

    modport control (
        input  request,
        input  address,
        input  direction,
        output ready,
        output status
    );

    modport data (
        input  write_data,
        input  write_strobe,
        output read_data
    );

endinterface
`default_nettype wire

// File: rtl/rggen_external_watchdog.sv
`default_nettype none
//==============================================================================
// Module      : rggen_external_watchdog
// Description : Counts enabled cycles and flags the last allowed cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module rggen_external_watchdog #(
    parameter int TIMEOUT_CYCLES = 1
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int c_COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_COUNT_WIDTH-1:0] c_LAST = c_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [c_COUNT_WIDTH-1:0] r_count;

    // Counting stops at the last cycle so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rggen_external_window.sv
`default_nettype none
//==============================================================================
// Module      : rggen_external_window
// Description : Bridges a register-block address window to an external bus
//               slave, with optional watchdog abort and registered response.
// Revision    : 1.0 - initial release
//==============================================================================
module rggen_external_window
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH  = 16,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS  = '0,
    parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS    = '0,
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     ADDRESS_MODE   = 0,
    parameter int                     RESPONSE_STAGE = 0,
    parameter int                     TIMEOUT_CYCLES = 0
)(
    input  logic              clk,
    input  logic              rst,
    rggen_register_if.control register_control_if,
    rggen_register_if.data    register_data_if,
    rggen_bus_if.master       bus_if,
    output logic              timeout
);

    localparam int c_STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int c_WORD_SHIFT   = $clog2(c_STROBE_WIDTH);
    localparam bit [ADDRESS_WIDTH-1:0] c_WINDOW_LAST = END_ADDRESS - START_ADDRESS;
    localparam bit [ADDRESS_WIDTH:0]   c_WINDOW_SIZE = {1'b0, c_WINDOW_LAST} + 1'b1;
    localparam int c_WINDOW_BITS  = $clog2(c_WINDOW_SIZE);
    localparam bit c_WORD_MODE    = (ADDRESS_MODE == int'(WORD_INDEX));
    localparam int c_RAW_EXT_WIDTH = c_WORD_MODE ? (c_WINDOW_BITS - c_WORD_SHIFT) : c_WINDOW_BITS;
    localparam int c_EXT_WIDTH    = (c_RAW_EXT_WIDTH < 1) ? 1 : c_RAW_EXT_WIDTH;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;
    localparam logic [1:0] c_GUARD = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [c_EXT_WIDTH-1:0]    r_address;
    rggen_direction            r_direction;
    logic [DATA_WIDTH-1:0]     r_write_data;
    logic [c_STROBE_WIDTH-1:0] r_write_strobe;
    logic [DATA_WIDTH-1:0]     r_read_data;
    rggen_status               r_status;

    logic [ADDRESS_WIDTH-1:0]  w_offset;
    logic [ADDRESS_WIDTH-1:0]  w_index;
    logic                      w_address_match;
    logic                      w_busy;
    logic                      w_start;
    logic                      w_done;
    logic                      w_expire;
    logic                      w_abort;

    // Offset wraps modulo 2^ADDRESS_WIDTH, so one compare covers both bounds.
    assign w_offset        = register_control_if.address - START_ADDRESS;
    assign w_index         = c_WORD_MODE ? (w_offset >> c_WORD_SHIFT) : w_offset;
    assign w_address_match = (w_offset <= c_WINDOW_LAST);

    assign w_busy  = (r_state == c_BUSY);
    assign w_start = (r_state == c_IDLE) && register_control_if.request && w_address_match;
    assign w_done  = w_busy && bus_if.done;
    assign w_abort = w_busy && !bus_if.done && w_expire;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            logic w_clear;
            assign w_clear = !w_busy;
            rggen_external_watchdog #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_watchdog (
                .clk    (clk),
                .rst    (rst),
                .clear  (w_clear),
                .enable (w_busy),
                .expire (w_expire)
            );
        end else begin : g_no_watchdog
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_BUSY;
                end
            end
            c_BUSY: begin
                if (w_done) begin
                    w_next_state = (RESPONSE_STAGE != 0) ? c_RESP : c_GUARD;
                end else if (w_abort) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_GUARD;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Request fields live only for the duration of the bus access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_address      <= '0;
            r_direction    <= RGGEN_READ;
            r_write_data   <= '0;
            r_write_strobe <= '0;
        end else if (w_start) begin
            r_address      <= c_EXT_WIDTH'(w_index);
            r_direction    <= register_control_if.direction;
            r_write_data   <= register_data_if.write_data;
            r_write_strobe <= register_data_if.write_strobe;
        end else if (w_done || w_abort) begin
            r_address      <= '0;
            r_direction    <= RGGEN_READ;
            r_write_data   <= '0;
            r_write_strobe <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
            r_status    <= RGGEN_OKAY;
        end else if (w_abort) begin
            r_read_data <= '0;
            r_status    <= RGGEN_SLAVE_ERROR;
        end else if (w_done && (RESPONSE_STAGE != 0)) begin
            r_read_data <= bus_if.read_data;
            r_status    <= bus_if.status;
        end
    end

    // RESP is reached either through the response register or a watchdog abort.
    generate
        if (RESPONSE_STAGE != 0) begin : g_registered_response
            assign register_control_if.ready  = (r_state == c_RESP);
            assign register_control_if.status = r_status;
            assign register_data_if.read_data = r_read_data;
        end else begin : g_direct_response
            assign register_control_if.ready  = w_done || (r_state == c_RESP);
            assign register_control_if.status = w_done ? bus_if.status : r_status;
            assign register_data_if.read_data = w_done ? bus_if.read_data : r_read_data;
        end
    endgenerate

    assign bus_if.request      = w_busy;
    assign bus_if.address      = ADDRESS_WIDTH'(r_address);
    assign bus_if.direction    = r_direction;
    assign bus_if.write_data   = r_write_data;
    assign bus_if.write_strobe = r_write_strobe;
    assign timeout             = w_abort;

endmodule
`default_nettype wire
